ram_bytelane_dp: RTL

- Parametrised successor to the core's single-write/dual-read scratch RAM, used for iram/dram storage.
- Generalises data width, depth and byte-lane count.
- Resolves same-address read/write collisions deterministically through a selectable read-during-write mode.
- Replaces the one-cycle reset wipe of the whole array with a sequential clear engine, which also accepts a soft-clear request, and flags out-of-range accesses.

---
 rtl/ram_bytelane_dp_if.sv | 30 +++
 rtl/ram_bytelane_dp.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ram_bytelane_dp_if.sv
// Bus bundle for ram_bytelane_dp: one masked write port, two read ports, clear/status.
interface ram_bytelane_dp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
);
  logic                 cs;
  logic                 clr;
  logic                 busy;
  logic                 we;
  logic [WIDTH/8-1:0]   byte_we;
  logic [ADDR_W-1:0]    waddr;
  logic [WIDTH-1:0]     wdata;
  logic                 re1;
  logic [ADDR_W-1:0]    raddr1;
  logic [WIDTH-1:0]     rdata1;
  logic                 re2;
  logic [ADDR_W-1:0]    raddr2;
  logic [WIDTH-1:0]     rdata2;
  logic                 err;

  modport master (
    output cs, clr, we, byte_we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  busy, rdata1, rdata2, err
  );

  modport slave (
    input  cs, clr, we, byte_we, waddr, wdata, re1, raddr1, re2, raddr2,
    output busy, rdata1, rdata2, err
  );
endinterface

// File: rtl/ram_bytelane_dp.sv
// Byte-lane masked scratch RAM: one write port, two registered read ports,
// sequential clear engine (after reset and on soft-clear), out-of-range flag.
module ram_bytelane_dp #(
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 9,
  parameter int RDW_MODE = 1
)(
  input  logic             clk,
  input  logic             rst,
  ram_bytelane_dp_if.slave bus
);
  localparam int                LANES    = WIDTH / 8;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [0:0]        S_CLEAR  = 1'b0;
  localparam logic [0:0]        S_IDLE   = 1'b1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_err;
  logic [WIDTH-1:0] r_rdata1, r_rdata2;

  logic             w_idle;
  logic             w_wr_oor, w_rd1_oor, w_rd2_oor;
  logic             w_wr_en, w_rd1_en, w_rd2_en;
  logic             w_hit1, w_hit2;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_old1, w_old2, w_new1, w_new2;

  // Expand the per-lane write mask to a bit mask for read-during-write merging.
  for (genvar g = 0; g < LANES; g++) begin : g_mask
    assign w_wmask[8*g +: 8] = {8{bus.byte_we[g]}};
  end

  assign w_idle    = (r_state == S_IDLE);
  // Compare with one extra bit so DEPTH == 2**ADDR_W still works; high address
  // bits are never dropped, so nothing at or above DEPTH aliases into the array.
  assign w_wr_oor  = ({1'b0, bus.waddr}  >= DEPTH_L);
  assign w_rd1_oor = ({1'b0, bus.raddr1} >= DEPTH_L);
  assign w_rd2_oor = ({1'b0, bus.raddr2} >= DEPTH_L);

  assign w_wr_en   = w_idle & bus.cs & bus.we & ~w_wr_oor;
  assign w_rd1_en  = w_idle & bus.cs & bus.re1;
  assign w_rd2_en  = w_idle & bus.cs & bus.re2;

  assign w_hit1    = w_wr_en & (bus.waddr == bus.raddr1);
  assign w_hit2    = w_wr_en & (bus.waddr == bus.raddr2);

  // Next read data: zero for out-of-range, else the array word, optionally
  // merged with the lanes being written this same cycle (write-first).
  always_comb begin
    w_old1 = w_rd1_oor ? '0 : r_mem[bus.raddr1[IDX_W-1:0]];
    w_old2 = w_rd2_oor ? '0 : r_mem[bus.raddr2[IDX_W-1:0]];
    w_new1 = w_old1;
    w_new2 = w_old2;
    if (RDW_MODE == 1) begin
      if (w_hit1) w_new1 = (w_old1 & ~w_wmask) | (bus.wdata & w_wmask);
      if (w_hit2) w_new2 = (w_old2 & ~w_wmask) | (bus.wdata & w_wmask);
    end
  end

  // Clear engine: walk every word once after reset or a soft-clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          if (bus.clr) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
      endcase
    end
  end

  // Array update: clear word while clearing (never while reset is held),
  // otherwise masked lane writes.
  always_ff @(posedge clk) begin
    if (rst && (r_state == S_CLEAR)) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.byte_we[l]) r_mem[bus.waddr[IDX_W-1:0]][8*l +: 8] <= bus.wdata[8*l +: 8];
      end
    end
  end

  // Registered read data and one-cycle out-of-range pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_idle & bus.cs & ((bus.we  & w_wr_oor)  |
                                  (bus.re1 & w_rd1_oor) |
                                  (bus.re2 & w_rd2_oor));
      if (w_rd1_en) r_rdata1 <= w_new1;
      if (w_rd2_en) r_rdata2 <= w_new2;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.err    = r_err;
  assign bus.rdata1 = r_rdata1;
  assign bus.rdata2 = r_rdata2;

endmodule
